fifo_read_stream_ctrl: RTL and testbench
========================================

Name: fifo_read_stream_ctrl

Overview:
Read-side sequencer for the async CDC FIFO, in the read_clk domain beside fifo_read_pointer_empty and the dual-port RAM.
- Accepts a burst command (N words) and drives read_enable from fifo_empty and local buffer credit.
- Absorbs the RAM's 1-cycle registered read latency in a 2-entry skid buffer.
- Delivers words on a valid/ready stream with out_last and a cmd_done pulse.

Parameters:
DATA_WIDTH, 8, width of FIFO data words
NUM_ADDRESS, 8, FIFO depth (power of 2); ADDR_WIDTH = $clog2(NUM_ADDRESS), LEN_WIDTH = ADDR_WIDTH+1

Ports:
read_clk  in  1  read-domain clock; all logic on rising edge
read_reset  in  1  synchronous, active-high reset
cmd_valid  in  1  burst command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_len  in  LEN_WIDTH  words to pop; 0 legal (empty burst)
fifo_empty  in  1  from fifo_read_pointer_empty
read_enable  out  1  pop strobe to the pointer block and RAM read port
read_data  in  DATA_WIDTH  RAM output, valid the cycle after read_enable
out_data  out  DATA_WIDTH  stream data
out_valid  out  1  stream valid
out_ready  in  1  consumer ready
out_last  out  1  marks the final word of the command
cmd_done  out  1  one-cycle pulse when the burst completes
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, synchronous: state=IDLE, issue_left=0, out_left=0, rd_pending=0, buffer empty, cmd_done=0.
  - While read_reset=1, read_enable, out_valid, out_last, cmd_ready and busy are all 0.
  - Words already popped are discarded. The FIFO pointer has advanced, so this is a defined data loss.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On accept with cmd_len!=0: issue_left=out_left=cmd_len, go to ISSUE.
  - On accept with cmd_len==0: stay in IDLE; cmd_done pulses the next cycle.
- ISSUE:
  - read_enable = !fifo_empty & (issue_left!=0) & (occ - pop + rd_pending < 2).
    - occ = buffer occupancy (0..2).
    - pop = out_valid & out_ready.
    - rd_pending = registered read_enable.
  - Each read_enable decrements issue_left.
  - When the last read issues (issue_left goes 1->0), go to DRAIN next cycle.
- DRAIN:
  - No reads issue.
  - When the last word hands off (out_left 1->0), go to IDLE; cmd_done=1 for exactly the following cycle.
- Stream timing:
  - rd_pending=1 captures read_data into the buffer at that edge.
  - out_valid is earliest 2 cycles after read_enable.
- Throughput: 1 word/cycle sustained when out_ready=1 and the FIFO is non-empty; the credit formula enforces this.
- Stream rules:
  - out_data/out_last are held stable while out_valid & !out_ready.
  - out_last=1 exactly when the presented word is the one that takes out_left to 0.
  - out_valid never deasserts without a handshake.
- fifo_empty=1:
  - read_enable is held 0 and the controller stalls in ISSUE indefinitely.
  - No timeout; the write side fills the FIFO.
- Buffer full: no overflow is possible; the credit rule guarantees at most 2 entries, including an in-flight read.
- Simultaneous push and pop on the buffer: both take effect and occ is unchanged.
- cmd_len up to 2^LEN_WIDTH-1 is legal, even if larger than NUM_ADDRESS; the burst simply spans refills.
- Arithmetic: counters are LEN_WIDTH unsigned and never wrap; decrements are gated at 0.

Decomposition:
- Package fifo_cdc_pkg:
  - state enum typedef (IDLE/ISSUE/DRAIN).
  - ADDR_WIDTH/LEN_WIDTH helper functions.
  - SKID_DEPTH=2 constant.
- Sub-module fifo_read_skid_buffer:
  - 2-entry registered FIFO with push/pop/occ.
  - Carries the data+last tag.
  - Instantiated once.

Test Plan:
- Reset mid-burst:
  - Stimulus: cmd_len=4, assert read_reset after 2 handshakes.
  - Response: next cycle read_enable=0, out_valid=0, busy=0, cmd_ready=0.
  - After release: cmd_ready=1, no stale words.
- Full-rate burst:
  - Stimulus: FIFO holds 8 words, out_ready=1, cmd_len=5.
  - Response: read_enable high 5 consecutive cycles; out_valid on cycles 2..6 after the first read; out_last on word 5; cmd_done the cycle after; exactly 5 pops.
- Empty stall:
  - Stimulus: cmd_len=3, fifo_empty=1 for 10 cycles, then 0.
  - Response: read_enable=0 and busy=1 throughout the stall; after it, 3 reads and 3 words, in order.
- Backpressure:
  - Stimulus: cmd_len=6, out_ready toggles 1,0,0,1...
  - Response: never more than 2 outstanding (occ+rd_pending<=2); out_data held while stalled; words match FIFO order.
- Zero-length command:
  - Stimulus: cmd_len=0.
  - Response: no read_enable; cmd_done pulses once the next cycle; cmd_ready stays 1.
- Back-to-back commands:
  - Stimulus: cmd_len=2 then cmd_len=1.
  - Response: second command accepted only in IDLE after cmd_done; out_last on word 2 and on word 3.

Source files
------------

// File: rtl/fifo_cdc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_cdc_pkg
//  Description : Shared types and constants for the async CDC FIFO read side.
//                Holds the read sequencer state type, the skid-buffer depth
//                and helpers deriving address/length widths from the depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_cdc_pkg;

    // Entries in the read-side skid buffer. Two is the minimum that hides the
    // one-cycle RAM latency while still sustaining one word per cycle.
    localparam int SKID_DEPTH = 2;

    // Read sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    // Address width of a FIFO with num_address entries (at least 1 bit).
    function automatic int addr_width(input int num_address);
        return (num_address > 1) ? $clog2(num_address) : 1;
    endfunction

    // Burst length width: one extra bit so a full-depth burst is encodable.
    function automatic int len_width(input int num_address);
        return addr_width(num_address) + 1;
    endfunction

endpackage : fifo_cdc_pkg
`default_nettype wire

// File: rtl/fifo_read_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_read_skid_buffer
//  Description : Two-entry registered FIFO that absorbs the RAM read latency.
//                Each entry carries a data word plus its end-of-burst tag.
//                Head entry is presented directly (first-word fall-through).
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_push          - write i_push_data this cycle
//                i_push_data     - entry to store ({last, data})
//                i_pop           - consume the head entry this cycle
//                o_valid         - head entry present
//                o_head_data     - head entry contents
//                o_occ           - number of stored entries (0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_skid_buffer
    import fifo_cdc_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_head_data,
    output logic [1:0]       o_occ
);

    localparam logic [1:0] c_occ_zero = 2'd0;
    localparam logic [1:0] c_occ_one  = 2'd1;
    localparam logic [1:0] c_occ_full = 2'(SKID_DEPTH);

    logic [WIDTH-1:0] r_mem [SKID_DEPTH];
    logic [1:0]       r_occ;
    logic             w_pop;
    logic             w_push;

    // Popping an empty buffer is ignored; a push into a full buffer is only
    // taken when a pop frees a slot in the same cycle.
    assign w_pop  = i_pop & (r_occ != c_occ_zero);
    assign w_push = i_push & ((r_occ != c_occ_full) | w_pop);

    // Entry 0 is always the head; a pop shifts entry 1 down.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ <= c_occ_zero;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == c_occ_zero) begin
                        r_mem[0] <= i_push_data;
                    end else begin
                        r_mem[1] <= i_push_data;
                    end
                    r_occ <= r_occ + c_occ_one;
                end
                2'b01: begin
                    r_mem[0] <= r_mem[1];
                    r_occ    <= r_occ - c_occ_one;
                end
                2'b11: begin
                    // Occupancy unchanged; the new entry lands behind
                    // whatever remains after the pop.
                    if (r_occ == c_occ_one) begin
                        r_mem[0] <= i_push_data;
                    end else begin
                        r_mem[0] <= r_mem[1];
                        r_mem[1] <= i_push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_valid     = (r_occ != c_occ_zero);
    assign o_head_data = r_mem[0];
    assign o_occ       = r_occ;

endmodule : fifo_read_skid_buffer
`default_nettype wire

// File: rtl/fifo_read_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_read_stream_ctrl
//  Description : Read-side sequencer for the async CDC FIFO (read_clk domain).
//                Accepts a burst command of cmd_len words, pops the FIFO when
//                it is non-empty and the skid buffer has credit, absorbs the
//                one-cycle RAM latency and streams the words out on a
//                valid/ready interface with out_last and a cmd_done pulse.
//  Ports       : read_clk, read_reset       - clock, sync active-high reset
//                cmd_valid/cmd_ready/cmd_len - burst command handshake
//                fifo_empty                  - FIFO empty flag (read domain)
//                read_enable                 - pop strobe to pointer + RAM
//                read_data                   - RAM data, valid 1 cycle later
//                out_data/out_valid/out_ready/out_last - output stream
//                cmd_done                    - one-cycle burst-complete pulse
//                busy                        - controller not IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_stream_ctrl
    import fifo_cdc_pkg::*;
#(
    parameter  int DATA_WIDTH  = 8,
    parameter  int NUM_ADDRESS = 8,
    localparam int LEN_WIDTH   = len_width(NUM_ADDRESS)
) (
    input  logic                  read_clk,
    input  logic                  read_reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  fifo_empty,
    output logic                  read_enable,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  cmd_done,
    output logic                  busy
);

    localparam logic [LEN_WIDTH-1:0] c_len_zero = '0;
    localparam logic [LEN_WIDTH-1:0] c_len_one  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2:0]           c_credit   = 3'(SKID_DEPTH);

    rd_state_t            r_state;
    logic [LEN_WIDTH-1:0] r_issue_left;   // reads still to issue
    logic [LEN_WIDTH-1:0] r_out_left;     // words still to hand off
    logic                 r_rd_pending;   // read issued last cycle, data on read_data now
    logic                 r_rd_last;      // that read was the final one of the burst
    logic                 r_cmd_done;

    logic                  w_run;
    logic                  w_cmd_accept;
    logic                  w_pop;
    logic                  w_credit_ok;
    logic                  w_read_enable;
    logic                  w_buf_valid;
    logic [DATA_WIDTH:0]   w_buf_head;
    logic [1:0]            w_buf_occ;

    // Every externally visible strobe is forced low while reset is held.
    assign w_run = ~read_reset;

    assign cmd_ready    = w_run & (r_state == IDLE);
    assign busy         = w_run & (r_state != IDLE);
    assign w_cmd_accept = cmd_valid & cmd_ready;

    assign out_valid = w_run & w_buf_valid;
    assign out_data  = w_buf_head[DATA_WIDTH-1:0];
    assign out_last  = out_valid & w_buf_head[DATA_WIDTH];
    assign w_pop     = out_valid & out_ready;
    assign cmd_done  = w_run & r_cmd_done;

    // Credit: entries that will be in the buffer next cycle, counting the
    // in-flight read, must stay below the depth for a new read to be safe.
    // Written as occ + rd_pending < depth + pop to avoid an unsigned borrow.
    assign w_credit_ok = ({1'b0, w_buf_occ} + {2'b00, r_rd_pending})
                         < (c_credit + {2'b00, w_pop});

    assign w_read_enable = w_run
                         & (r_state == ISSUE)
                         & ~fifo_empty
                         & (r_issue_left != c_len_zero)
                         & w_credit_ok;

    assign read_enable = w_read_enable;

    // Sequencer. Counters only move while non-zero so they can never wrap.
    always_ff @(posedge read_clk) begin
        if (read_reset) begin
            r_state      <= IDLE;
            r_issue_left <= c_len_zero;
            r_out_left   <= c_len_zero;
            r_rd_pending <= 1'b0;
            r_rd_last    <= 1'b0;
            r_cmd_done   <= 1'b0;
        end else begin
            r_rd_pending <= w_read_enable;
            r_rd_last    <= w_read_enable & (r_issue_left == c_len_one);
            r_cmd_done   <= 1'b0;

            if (w_read_enable && (r_issue_left != c_len_zero)) begin
                r_issue_left <= r_issue_left - c_len_one;
            end
            if (w_pop && (r_out_left != c_len_zero)) begin
                r_out_left <= r_out_left - c_len_one;
            end

            case (r_state)
                IDLE: begin
                    if (w_cmd_accept) begin
                        if (cmd_len != c_len_zero) begin
                            r_issue_left <= cmd_len;
                            r_out_left   <= cmd_len;
                            r_state      <= ISSUE;
                        end else begin
                            // Empty burst completes immediately.
                            r_cmd_done <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (w_read_enable && (r_issue_left == c_len_one)) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_pop && (r_out_left == c_len_one)) begin
                        r_state    <= IDLE;
                        r_cmd_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // The RAM word appears one cycle after read_enable; capture it together
    // with the end-of-burst tag of the read that produced it.
    fifo_read_skid_buffer #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk         (read_clk),
        .rst         (read_reset),
        .i_push      (r_rd_pending),
        .i_push_data ({r_rd_last, read_data}),
        .i_pop       (w_pop),
        .o_valid     (w_buf_valid),
        .o_head_data (w_buf_head),
        .o_occ       (w_buf_occ)
    );

endmodule : fifo_read_stream_ctrl
`default_nettype wire

// File: tb/tb_fifo_read_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_read_stream_ctrl
//  Description : Self-checking bench for fifo_read_stream_ctrl. Models the
//                FIFO + RAM environment, predicts the output stream from the
//                FIFO contents and accepted command lengths, and pins key
//                timing with hand-computed literal patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_read_stream_ctrl;

    localparam int DW = 8;
    localparam int NA = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len;
    logic          fifo_empty;
    logic          read_enable;
    logic [DW-1:0] read_data = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          cmd_done;
    logic          busy;

    always #5 clk = ~clk;

    fifo_read_stream_ctrl #(
        .DATA_WIDTH  (DW),
        .NUM_ADDRESS (NA)
    ) dut (
        .read_clk    (clk),
        .read_reset  (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_len     (cmd_len),
        .fifo_empty  (fifo_empty),
        .read_enable (read_enable),
        .read_data   (read_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .cmd_done    (cmd_done),
        .busy        (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- FIFO + registered RAM environment ----------------
    logic [DW-1:0] mem [0:255];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic          force_empty = 1'b0;

    assign fifo_empty = force_empty || (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (read_enable && (wr_ptr != rd_ptr)) begin
            read_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // ---------------- out_ready driver ----------------
    logic rdy_level = 1'b1;
    logic bp_mode   = 1'b0;
    int   bp_idx    = 0;
    always @(posedge clk) begin
        #2;
        if (bp_mode) begin
            out_ready = (bp_idx == 0);    // 1,0,0 repeating
            bp_idx    = (bp_idx + 1) % 3;
        end else begin
            out_ready = rdy_level;
            bp_idx    = 0;
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    int      cmdq[$];       // lengths of accepted non-empty bursts
    int      exp_ptr    = 0; // next FIFO word the stream must deliver
    int      word_cnt   = 0; // words delivered of the head burst
    logic    done_exp   = 1'b0;
    int      issued     = 0;
    int      handed     = 0;
    int      len_total  = 0;
    logic    prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic    prev_last;
    int      hs_count   = 0;
    int      last_count = 0;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_read_enable", read_enable, 0);
            check("rst_out_valid",   out_valid,   0);
            check("rst_out_last",    out_last,    0);
            check("rst_cmd_ready",   cmd_ready,   0);
            check("rst_busy",        busy,        0);
            // Words already popped are lost; the stream resumes at the FIFO head.
            exp_ptr    = rd_ptr;
            cmdq.delete();
            word_cnt   = 0;
            done_exp   = 1'b0;
            issued     = 0;
            handed     = 0;
            len_total  = 0;
            prev_stall = 1'b0;
        end else begin
            check("cmd_done", cmd_done, done_exp);
            done_exp = 1'b0;
            check("busy",      busy,      cmdq.size() != 0);
            check("cmd_ready", cmd_ready, cmdq.size() == 0);
            check("outstanding_le_2", (issued - handed) <= 2, 1);
            if (read_enable) begin
                check("read_while_empty", fifo_empty, 0);
                check("read_beyond_cmd",  issued < len_total, 1);
            end
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data",  out_data,  prev_data);
                check("hold_last",  out_last,  prev_last);
            end
            if (out_valid && out_ready) begin
                if (cmdq.size() == 0) begin
                    check("word_without_cmd", out_valid, 0);
                end else begin
                    check("out_data", out_data, mem[exp_ptr]);
                    check("out_last", out_last, (word_cnt + 1) == cmdq[0]);
                    exp_ptr++;
                    word_cnt++;
                    if (word_cnt == cmdq[0]) begin
                        void'(cmdq.pop_front());
                        word_cnt = 0;
                        done_exp = 1'b1;
                    end
                end
                handed++;
                hs_count++;
                if (out_last) last_count++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (read_enable) issued++;
            if (cmd_valid && cmd_ready) begin
                if (cmd_len == 0) begin
                    done_exp = 1'b1;
                end else begin
                    cmdq.push_back(int'(cmd_len));
                    len_total += int'(cmd_len);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_word(input logic [DW-1:0] v);
        mem[wr_ptr] = v;
        wr_ptr      = wr_ptr + 1;
    endtask

    task automatic send_cmd(input int len);
        logic ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_len   = LW'(len);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("cmd_accept_timeout", cmd_ready, 1);
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (cmdq.size() == 0 && !busy && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({name, "_idle_timeout"}, busy, 0);
        @(posedge clk);
        #2;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic [9:0] re_pat, ov_pat, done_pat, last_pat;
        logic [3:0] zre, zdone, zrdy;
        int p0, h0, l0, cnt_a, cnt_b;
        logic [DW-1:0] first_word;
        logic ok;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_cmd_ready", cmd_ready, 1);
        check("post_reset_busy",      busy,      0);
        @(posedge clk);
        #2;

        // Full-rate burst: 8 words queued, cmd_len=5, out_ready=1.
        for (int i = 0; i < 8; i++) push_word(DW'(8'hA0 + i));
        p0 = rd_ptr;
        send_cmd(5);
        re_pat = '0; ov_pat = '0; done_pat = '0; last_pat = '0;
        first_word = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            re_pat   = {re_pat[8:0],   read_enable};
            ov_pat   = {ov_pat[8:0],   out_valid};
            done_pat = {done_pat[8:0], cmd_done};
            last_pat = {last_pat[8:0], out_last};
            if (i == 2) first_word = out_data;
        end
        check("burst_read_pattern",  re_pat,   10'b1111100000);
        check("burst_valid_pattern", ov_pat,   10'b0011111000);
        check("burst_last_pattern",  last_pat, 10'b0000001000);
        check("burst_done_pattern",  done_pat, 10'b0000000100);
        check("burst_first_word",    first_word, 8'hA0);
        check("burst_pop_count",     rd_ptr - p0, 5);
        @(posedge clk);
        #2;

        // Empty stall: FIFO held empty for 10 cycles with cmd_len=3.
        force_empty = 1'b1;
        p0 = rd_ptr;
        h0 = hs_count;
        send_cmd(3);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (read_enable) cnt_a++;
            if (!busy) cnt_b++;
        end
        check("stall_reads",     cnt_a, 0);
        check("stall_busy_low",  cnt_b, 0);
        @(posedge clk);
        #2;
        force_empty = 1'b0;
        wait_idle("stall");
        check("stall_pop_count", rd_ptr - p0, 3);
        check("stall_words",     hs_count - h0, 3);

        // Backpressure: out_ready 1,0,0 repeating, cmd_len=6.
        for (int i = 0; i < 6; i++) push_word(DW'(8'hB0 + i));
        p0 = rd_ptr;
        h0 = hs_count;
        bp_mode = 1'b1;
        send_cmd(6);
        wait_idle("backpressure");
        bp_mode = 1'b0;
        check("bp_pop_count", rd_ptr - p0, 6);
        check("bp_words",     hs_count - h0, 6);

        // Zero-length command.
        p0 = rd_ptr;
        send_cmd(0);
        zre = '0; zdone = '0; zrdy = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            zre   = {zre[2:0],   read_enable};
            zdone = {zdone[2:0], cmd_done};
            zrdy  = {zrdy[2:0],  cmd_ready};
        end
        check("zero_reads",     zre,   4'b0000);
        check("zero_done",      zdone, 4'b1000);
        check("zero_cmd_ready", zrdy,  4'b1111);
        check("zero_pops",      rd_ptr - p0, 0);
        @(posedge clk);
        #2;

        // Back-to-back commands 2 then 1.
        for (int i = 0; i < 3; i++) push_word(DW'(8'hC0 + i));
        h0 = hs_count;
        l0 = last_count;
        send_cmd(2);
        send_cmd(1);
        wait_idle("b2b");
        check("b2b_words", hs_count - h0, 3);
        check("b2b_lasts", last_count - l0, 2);

        // Reset mid-burst after two handshakes.
        for (int i = 0; i < 4; i++) push_word(DW'(8'hD0 + i));
        h0 = hs_count;
        send_cmd(4);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (hs_count - h0 >= 2) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("rst_mid_wait_timeout", hs_count - h0, 2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_read_enable", read_enable, 0);
        check("mid_rst_out_valid",   out_valid,   0);
        check("mid_rst_busy",        busy,        0);
        check("mid_rst_cmd_ready",   cmd_ready,   0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_cmd_ready", cmd_ready, 1);
        cnt_a = (out_valid ? 1 : 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) cnt_a++;
        end
        check("after_rst_no_stale", cnt_a, 0);
        @(posedge clk);
        #2;
        push_word(8'hE0);
        push_word(8'hE1);
        h0 = hs_count;
        send_cmd(2);
        wait_idle("after_rst");
        check("after_rst_words", hs_count - h0, 2);
        check("after_rst_ptr",   exp_ptr, wr_ptr);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_fifo_read_stream_ctrl
`default_nettype wire
